// File: rtl/mul_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mul_issue_ctrl_pkg: shared widths, FSM encoding and defaults. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mul_issue_ctrl_pkg;

  localparam int c_OP_W        = 32;
  localparam int c_RES_W       = 64;
  localparam int c_TIMEOUT_DEF = 80;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_CAPT = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  function automatic logic [c_RES_W-1:0] sext_op(input logic [c_OP_W-1:0] v);
    return {{(c_RES_W-c_OP_W){v[c_OP_W-1]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_operand_fifo.sv
// ---------------------------------------------------------------------------
// mul_operand_fifo: DEPTH-entry FIFO of packed {a,b} operand pairs. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_operand_fifo
  import mul_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_push,
  input  logic [2*c_OP_W-1:0]  i_data,
  input  logic                 i_pop,
  output logic [2*c_OP_W-1:0]  o_data,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

  logic [2*c_OP_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;
  logic                w_do_push;
  logic                w_do_pop;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_full    = (r_count == c_FULL);
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mul_issue_ctrl: queues operand pairs and sequences an external multiplier. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = c_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [c_OP_W-1:0]  i_in_a,
  input  logic [c_OP_W-1:0]  i_in_b,
  output logic [c_OP_W-1:0]  o_mul_opera1,
  output logic [c_RES_W-1:0] o_mul_opera2,
  output logic               o_mul_start,
  output logic               o_mul_reset,
  input  logic               i_mul_valid,
  input  logic [c_RES_W-1:0] i_mul_result,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [c_RES_W-1:0] o_out_result,
  output logic               o_busy,
  output logic               o_timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_TO_LAST = CW'(TIMEOUT - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_load_cnt;
  logic [CW-1:0]        r_run_cnt;
  logic [c_OP_W-1:0]    r_op_a;
  logic [c_OP_W-1:0]    r_op_b;
  logic                 r_mul_start;
  logic                 r_mul_reset;
  logic                 r_rdy_en;
  logic                 r_timeout_err;
  logic                 r_out_valid;
  logic [c_RES_W-1:0]   r_out_result;

  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [2*c_OP_W-1:0]  w_fifo_data;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_capture;
  logic                 w_abort;
  logic                 w_out_free;

  mul_operand_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({i_in_a, i_in_b}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // r_rdy_en keeps in_ready low while reset is held and rises on the first clock after.
  assign o_in_ready    = r_rdy_en & ~w_fifo_full;
  assign w_push        = i_in_valid & o_in_ready;
  assign w_out_free    = ~r_out_valid | i_out_ready;
  assign o_mul_opera1  = r_op_a;
  assign o_mul_opera2  = sext_op(r_op_b);
  assign o_mul_start   = r_mul_start;
  assign o_mul_reset   = r_mul_reset;
  assign o_out_valid   = r_out_valid;
  assign o_out_result  = r_out_result;
  assign o_timeout_err = r_timeout_err;
  assign o_busy        = (r_state != ST_IDLE) | ~w_fifo_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (r_load_cnt) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_mul_valid) begin
          w_state_nxt = ST_CAPT;
        end else if (r_run_cnt == c_TO_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CAPT: begin
        if (w_out_free) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!r_out_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_cnt    <= 1'b0;
      r_run_cnt     <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_mul_start   <= 1'b1;
      r_mul_reset   <= 1'b1;
      r_rdy_en      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_rdy_en      <= 1'b1;
      r_load_cnt    <= (r_state == ST_LOAD) ? ~r_load_cnt : 1'b0;
      r_run_cnt     <= (r_state == ST_RUN) ? r_run_cnt + 1'b1 : '0;
      // Start is registered from the next state so it is high exactly for the LOAD cycles.
      r_mul_start   <= (w_state_nxt == ST_LOAD);
      r_mul_reset   <= w_abort;
      r_timeout_err <= r_timeout_err | w_abort;
      if (w_pop) {r_op_a, r_op_b} <= w_fifo_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
    end else if (w_capture) begin
      r_out_valid  <= 1'b1;
      r_out_result <= i_mul_result;
    end else if (i_out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_issue_ctrl: scenario tasks against a product scoreboard and a multiplier model. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mul_issue_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] mul_opera1;
  logic [63:0] mul_opera2;
  logic        mul_start;
  logic        mul_reset;
  logic        mul_valid = 1'b0;
  logic [63:0] mul_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  logic        hang_once = 1'b0;
  logic        m_prev_start = 1'b1;
  logic        m_busy = 1'b0;
  logic        m_hang = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_prod = '0;

  always #5 clk = ~clk;

  mul_issue_ctrl #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_a        (in_a),
    .i_in_b        (in_b),
    .o_mul_opera1  (mul_opera1),
    .o_mul_opera2  (mul_opera2),
    .o_mul_start   (mul_start),
    .o_mul_reset   (mul_reset),
    .i_mul_valid   (mul_valid),
    .i_mul_result  (mul_result),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_result  (out_result),
    .o_busy        (busy),
    .o_timeout_err (timeout_err)
  );

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Multiplier model: launches on the falling edge of start, answers after 0-4 cycles,
  // holds valid/result until start or reset rises; hang_once makes it never answer.
  always @(negedge clk) begin
    if (!rst_n || mul_reset || mul_start) begin
      mul_valid = 1'b0;
      m_busy    = 1'b0;
    end else if (m_prev_start) begin
      m_busy = 1'b1;
      m_hang = hang_once;
      m_cnt  = int'($urandom_range(0, 4));
      m_prod = 64'(longint'($signed(mul_opera1)) * longint'($signed(mul_opera2)));
    end
    if (m_busy && !m_hang && !mul_valid) begin
      if (m_cnt == 0) begin
        mul_valid  = 1'b1;
        mul_result = m_prod;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    m_prev_start = mul_start;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back(out_result);
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (in_ready) exp_q.push_back(ref_prod(a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [201:0] got_v;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got_v = {in_ready, out_valid, mul_start, mul_reset, timeout_err, busy,
             out_result, mul_opera1, mul_opera2, 4'b0};
    total++;
    if (got_v !== {6'b001100, 64'd0, 32'd0, 64'd0, 4'b0}) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", got_v[201:196], 6'b001100);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int w;
    int hi = 0;
    int k = 0;
    logic seen = 1'b0;
    out_ready = 1'b1;
    push(32'd3, 32'hFFFF_FFFB, w);
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (mul_start) begin
        hi++;
        seen = 1'b1;
        if (hi == 1) begin
          total++;
          if (mul_opera1 !== 32'd3 || mul_opera2 !== 64'hFFFF_FFFF_FFFF_FFFB) begin
            bad++;
            $display("FAIL basic_operands got=%h/%h want=3/fffffffffffffffb", mul_opera1, mul_opera2);
          end
        end
      end else if (seen) begin
        break;
      end
    end
    total++;
    if (hi != 2) begin
      bad++;
      $display("FAIL basic_start_width got=%0d want=2", hi);
    end
    wait_got(1, 100);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      bad++;
      $display("FAIL basic_result count=%0d got=%h want=fffffffffffffff1",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'd0);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int w;
    out_ready = 1'b1;
    // The first pair leaves the FIFO one cycle after arriving, so DEPTH+1 pairs
    // are taken without a stall before the FIFO reports full.
    for (int i = 0; i < DEPTH + 1; i++) begin
      push($urandom, $urandom, w);
      total++;
      if (w != 0) begin
        bad++;
        $display("FAIL b2b_accept_%0d waited=%0d want=0", i, w);
      end
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_full_ready got=%b want=0", in_ready);
    end
    wait_got(DEPTH + 1, 600);
    total++;
    if (got_q.size() != DEPTH + 1) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=%0d", got_q.size(), DEPTH + 1);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_result_%0d got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_hold();
    int w;
    int changes = 0;
    logic [63:0] first_val = '0;
    logic have_first = 1'b0;
    out_ready = 1'b0;
    push($urandom, $urandom, w);
    push($urandom, $urandom, w);
    repeat (40) begin
      @(negedge clk);
      if (out_valid) begin
        if (have_first && out_result !== first_val) changes++;
        first_val  = out_result;
        have_first = 1'b1;
      end
    end
    total++;
    if (out_valid !== 1'b1 || out_result !== exp_q[0] || changes != 0) begin
      bad++;
      $display("FAIL hold_first valid=%b got=%h want=%h changes=%0d",
               out_valid, out_result, exp_q[0], changes);
    end
    total++;
    if (busy !== 1'b1 || got_q.size() != 0) begin
      bad++;
      $display("FAIL hold_pending busy=%b delivered=%0d want 1/0", busy, got_q.size());
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_got(2, 50);
    total++;
    if (got_q.size() != 2) begin
      bad++;
      $display("FAIL hold_count got=%0d want=2", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL hold_result_%0d got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_timeout();
    int w;
    int k = 0;
    int idx = 0;
    logic seen = 1'b0;
    out_ready = 1'b1;
    hang_once = 1'b1;
    push($urandom, $urandom, w);
    push(32'd7, 32'hFFFF_FFFE, w);
    void'(exp_q.pop_front());
    while (k < 20 && idx == 0) begin
      @(negedge clk);
      k++;
      if (mul_start) seen = 1'b1;
      else if (seen) idx = 1;
    end
    while (idx > 0 && idx < 200 && !mul_reset) begin
      @(negedge clk);
      idx++;
    end
    hang_once = 1'b0;
    total++;
    if (idx != TIMEOUT + 1) begin
      bad++;
      $display("FAIL timeout_cycle got=%0d want=%0d", idx, TIMEOUT + 1);
    end
    @(negedge clk);
    total++;
    if (mul_reset !== 1'b0 || timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_pulse mul_reset=%b timeout_err=%b want 0/1", mul_reset, timeout_err);
    end
    wait_got(1, 100);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 64'hFFFF_FFFF_FFFF_FFF2) begin
      bad++;
      $display("FAIL timeout_next count=%0d got=%h want=fffffffffffffff2",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'd0);
    end
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky got=%b want=1", timeout_err);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int w;
    int k = 0;
    logic [201:0] got_v;
    out_ready = 1'b0;
    push($urandom, $urandom, w);
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    hang_once = 1'b1;
    for (int i = 0; i < 4; i++) push($urandom, $urandom, w);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    got_v = {in_ready, out_valid, mul_start, mul_reset, timeout_err, busy,
             out_result, mul_opera1, mul_opera2, 4'b0};
    total++;
    if (got_v !== {6'b001100, 64'd0, 32'd0, 64'd0, 4'b0}) begin
      bad++;
      $display("FAIL midreset_state got=%h want=%h", got_v[201:196], 6'b001100);
    end
    repeat (2) @(posedge clk);
    #1;
    hang_once = 1'b0;
    got_q.delete();
    exp_q.delete();
    out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    total++;
    if (got_q.size() != 0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_after emitted=%0d busy=%b out_valid=%b want 0/0/0",
               got_q.size(), busy, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_min();
    int w;
    out_ready = 1'b1;
    push(32'h8000_0000, 32'h8000_0000, w);
    wait_got(1, 100);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 64'h4000_0000_0000_0000) begin
      bad++;
      $display("FAIL min_result count=%0d got=%h want=4000000000000000",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'd0);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    int n_ops = 40;
    logic done = 1'b0;
    fork
      begin
        int w;
        for (int i = 0; i < n_ops; i++) begin
          push($urandom, $urandom, w);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_got(n_ops, 3000);
    total++;
    if (got_q.size() != n_ops || exp_q.size() != n_ops) begin
      bad++;
      $display("FAIL random_count got=%0d queued=%0d want=%0d", got_q.size(), exp_q.size(), n_ops);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL random_result_%0d got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_timeout();
    test_reset_mid();
    test_min();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
